// File: rtl/can_pkg.sv
// Shared CAN transmit types: frame layout and mailbox FSM states.
// Frame fields are packed ID first so the 99-bit slot image is stable.
package can_pkg;

  localparam int CAN_ID_W    = 29;
  localparam int CAN_DLC_W   = 4;
  localparam int CAN_DATA_W  = 64;
  localparam int CAN_FRAME_W = 99;

  typedef struct packed {
    logic [CAN_ID_W-1:0]   ID;
    logic [CAN_DLC_W-1:0]  size;
    logic                  RTR;
    logic                  EXT;
    logic [CAN_DATA_W-1:0] data;
  } can_frame_t;

  typedef enum logic [1:0] {
    IDLE,
    READY,
    ACTIVE,
    WAIT
  } tx_mb_state_t;

endpackage

// File: rtl/can_frame_fifo.sv
// Circular frame buffer with whole-queue and keep-head flushes.
// Flushes are applied before the push/pop of the same cycle.
module can_frame_fifo
  import can_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush_all,
  input  logic                   i_flush_tail,
  input  logic [CAN_FRAME_W-1:0] i_frame,
  output logic [CAN_FRAME_W-1:0] o_head,
  output logic [AW:0]            o_count,
  output logic [AW:0]            o_count_n,
  output logic                   o_empty,
  output logic                   o_overflow
);

  logic [CAN_FRAME_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]          r_rd;
  logic [AW-1:0]          r_wr;
  logic [AW-1:0]          w_wr_base;
  logic [AW:0]            r_cnt;
  logic [AW:0]            w_cnt_base;
  logic                   w_push;
  logic                   w_pop;

  always_comb begin
    w_wr_base  = r_wr;
    w_cnt_base = r_cnt;
    if (i_flush_all) begin
      w_wr_base  = r_rd;
      w_cnt_base = '0;
    end else if (i_flush_tail && (r_cnt != '0)) begin
      w_wr_base  = r_rd + AW'(1);
      w_cnt_base = (AW+1)'(1);
    end
    w_pop      = i_pop && (w_cnt_base != '0);
    // a simultaneous pop frees the slot a full-queue push needs
    w_push     = i_push &&
                 ((w_cnt_base != (AW+1)'(DEPTH)) || w_pop);
    o_overflow = i_push && !w_push;
    o_count_n  = w_cnt_base + (AW+1)'(w_push)
               - (AW+1)'(w_pop);
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[w_wr_base] <= i_frame;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      r_rd  <= r_rd + AW'(w_pop);
      r_wr  <= w_wr_base + AW'(w_push);
      r_cnt <= o_count_n;
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_cnt;
  assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/can_tx_mailbox.sv
// CAN transmit mailbox: in-order frame queue offered to the TX unit,
// with arbitration retry, drop after MAX_RETRY losses, and abort.
module can_tx_mailbox
  import can_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MAX_RETRY = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        push_i,
  input  logic [28:0] push_ID_i,
  input  logic [3:0]  push_size_i,
  input  logic        push_RTR_i,
  input  logic        push_EXT_i,
  input  logic [63:0] push_data_i,
  input  logic        abort_i,
  input  logic        tx_busy,
  input  logic        tx_done,
  input  logic        tx_arb_loss,
  output logic        tx_pkt_ready,
  output logic [28:0] tx_ID,
  output logic [3:0]  tx_pkt_size,
  output logic        tx_RTR,
  output logic        tx_EXT,
  output logic [63:0] tx_data,
  output logic [4:0]  occupancy,
  output logic        full,
  output logic        empty,
  output logic        push_overflow,
  output logic        sent,
  output logic        dropped
);

  localparam int AW = $clog2(DEPTH);

  tx_mb_state_t r_state;
  tx_mb_state_t w_state_n;
  can_frame_t   w_in;
  can_frame_t   w_head;
  can_frame_t   r_tx;
  logic [3:0]   r_retry;
  logic [3:0]   w_retry_n;
  logic [3:0]   w_inc;
  logic [AW:0]  w_count;
  logic [AW:0]  w_count_n;
  logic         w_empty;
  logic         w_ovf;
  logic         w_pop;
  logic         w_load;
  logic         w_flush_all;
  logic         w_flush_tail;
  logic         w_sent;
  logic         w_drop;
  logic         r_rdy;
  logic         r_sent;
  logic         r_drop;
  logic         r_ovf;
  logic         r_empty;

  assign w_in = {push_ID_i, push_size_i, push_RTR_i,
                 push_EXT_i, push_data_i};

  can_frame_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk        (wb_clk_i),
    .i_rst        (wb_rst_i),
    .i_push       (push_i),
    .i_pop        (w_pop),
    .i_flush_all  (w_flush_all),
    .i_flush_tail (w_flush_tail),
    .i_frame      (w_in),
    .o_head       (w_head),
    .o_count      (w_count),
    .o_count_n    (w_count_n),
    .o_empty      (w_empty),
    .o_overflow   (w_ovf)
  );

  assign w_inc = (r_retry == 4'hF) ? 4'hF : r_retry + 4'd1;

  always_comb begin
    w_state_n    = r_state;
    w_retry_n    = r_retry;
    w_load       = 1'b0;
    w_pop        = 1'b0;
    w_sent       = 1'b0;
    w_drop       = 1'b0;
    w_flush_all  = 1'b0;
    w_flush_tail = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (abort_i) begin
          w_flush_all = 1'b1;
          w_retry_n   = '0;
        end else if (!w_empty) begin
          w_load    = 1'b1;
          w_state_n = READY;
        end
      end
      READY: begin
        if (abort_i) begin
          w_flush_all = 1'b1;
          w_retry_n   = '0;
          w_state_n   = IDLE;
        end else if (tx_busy) begin
          w_state_n = ACTIVE;
        end
      end
      ACTIVE: begin
        w_flush_tail = abort_i;
        if (tx_done) begin
          w_pop     = 1'b1;
          w_sent    = 1'b1;
          w_retry_n = '0;
          w_state_n = IDLE;
        end else if (tx_arb_loss) begin
          if ((MAX_RETRY != 0) && (int'(w_inc) == MAX_RETRY)) begin
            w_pop     = 1'b1;
            w_drop    = 1'b1;
            w_retry_n = '0;
            w_state_n = IDLE;
          end else begin
            w_retry_n = w_inc;
            w_state_n = WAIT;
          end
        end else if (!tx_busy) begin
          // error frame: retry without charging the retry budget
          w_state_n = WAIT;
        end
      end
      WAIT: begin
        w_flush_tail = abort_i;
        if (!tx_busy) w_state_n = READY;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
      r_retry <= '0;
      r_tx    <= '0;
      r_rdy   <= 1'b0;
      r_sent  <= 1'b0;
      r_drop  <= 1'b0;
      r_ovf   <= 1'b0;
      r_empty <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_retry <= w_retry_n;
      if (w_load) r_tx <= w_head;
      r_rdy   <= (w_state_n == READY);
      r_sent  <= w_sent;
      r_drop  <= w_drop;
      r_ovf   <= w_ovf;
      r_empty <= (w_count_n == '0);
    end
  end

  assign tx_pkt_ready  = r_rdy;
  assign tx_ID         = r_tx.ID;
  assign tx_pkt_size   = r_tx.size;
  assign tx_RTR        = r_tx.RTR;
  assign tx_EXT        = r_tx.EXT;
  assign tx_data       = r_tx.data;
  assign occupancy     = 5'(w_count);
  assign full          = (w_count == (AW+1)'(DEPTH));
  assign empty         = r_empty;
  assign push_overflow = r_ovf;
  assign sent          = r_sent;
  assign dropped       = r_drop;

endmodule

// File: tb/tb_can_tx_mailbox.sv
// Directed bench for can_tx_mailbox (DEPTH=4, MAX_RETRY=3):
// a vector table plus hand sequences for reset and the first frame.
module tb_can_tx_mailbox;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push = 1'b0;
  logic [28:0] pid = '0;
  logic [3:0]  psz = '0;
  logic        prtr = 1'b0;
  logic        pext = 1'b0;
  logic [63:0] pdat = '0;
  logic        abort = 1'b0;
  logic        busy = 1'b0;
  logic        done = 1'b0;
  logic        loss = 1'b0;
  logic        rdy;
  logic [28:0] tid;
  logic [3:0]  tsz;
  logic        trtr;
  logic        text;
  logic [63:0] tdat;
  logic [4:0]  occ;
  logic        full;
  logic        empty;
  logic        ovf;
  logic        sent;
  logic        drop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  can_tx_mailbox #(.DEPTH(4), .MAX_RETRY(3)) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .push_i        (push),
    .push_ID_i     (pid),
    .push_size_i   (psz),
    .push_RTR_i    (prtr),
    .push_EXT_i    (pext),
    .push_data_i   (pdat),
    .abort_i       (abort),
    .tx_busy       (busy),
    .tx_done       (done),
    .tx_arb_loss   (loss),
    .tx_pkt_ready  (rdy),
    .tx_ID         (tid),
    .tx_pkt_size   (tsz),
    .tx_RTR        (trtr),
    .tx_EXT        (text),
    .tx_data       (tdat),
    .occupancy     (occ),
    .full          (full),
    .empty         (empty),
    .push_overflow (ovf),
    .sent          (sent),
    .dropped       (drop)
  );

  typedef struct {
    logic        push;
    logic [28:0] id;
    logic        busy;
    logic        done;
    logic        loss;
    logic        abort;
    logic        rdy;
    logic [28:0] eid;
    logic [4:0]  occ;
    logic        sent;
    logic        drop;
    logic        ovf;
  } vec_t;

  vec_t vt[$];

  function automatic logic [63:0] dat(input logic [28:0] id);
    return {3'b000, id, 3'b111, ~id};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic a(input logic p, input logic [28:0] id,
                   input logic b, input logic d, input logic l,
                   input logic ab, input logic r,
                   input logic [28:0] eid, input logic [4:0] o,
                   input logic s, input logic dr, input logic ov);
    vec_t v;
    v.push = p;  v.id = id;   v.busy = b;  v.done = d;
    v.loss = l;  v.abort = ab; v.rdy = r;  v.eid = eid;
    v.occ = o;   v.sent = s;  v.drop = dr; v.ovf = ov;
    vt.push_back(v);
  endtask

  task automatic set(input logic p, input logic [28:0] id,
                     input logic [3:0] sz, input logic r,
                     input logic e, input logic [63:0] d,
                     input logic b, input logic dn, input logic l,
                     input logic ab);
    @(negedge clk);
    push = p;  pid = id;  psz = sz;  prtr = r;  pext = e;
    pdat = d;  busy = b;  done = dn; loss = l;  abort = ab;
  endtask

  task automatic setv(input logic p, input logic [28:0] id,
                      input logic b, input logic dn,
                      input logic l, input logic ab);
    set(p, id, id[3:0], id[0], id[1], dat(id), b, dn, l, ab);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // first frame, overflow, same-cycle push+pop, pointer wrap
    a(1,'h10,0,0,0,0, 0,'h123,1,0,0,0);
    a(1,'h11,0,0,0,0, 1,'h10, 2,0,0,0);
    a(1,'h12,0,0,0,0, 1,'h10, 3,0,0,0);
    a(1,'h13,0,0,0,0, 1,'h10, 4,0,0,0);
    a(1,'h14,0,0,0,0, 1,'h10, 4,0,0,1);
    a(0,0,   1,0,0,0, 0,'h10, 4,0,0,0);
    a(1,'h15,1,1,0,0, 0,'h10, 4,1,0,0);
    a(0,0,   0,0,0,0, 1,'h11, 4,0,0,0);
    a(0,0,   1,0,0,0, 0,'h11, 4,0,0,0);
    a(0,0,   1,1,0,0, 0,'h11, 3,1,0,0);
    a(0,0,   0,0,0,0, 1,'h12, 3,0,0,0);
    a(0,0,   1,0,0,0, 0,'h12, 3,0,0,0);
    a(0,0,   1,1,0,0, 0,'h12, 2,1,0,0);
    a(0,0,   0,0,0,0, 1,'h13, 2,0,0,0);
    a(0,0,   1,0,0,0, 0,'h13, 2,0,0,0);
    a(0,0,   1,1,0,0, 0,'h13, 1,1,0,0);
    a(0,0,   0,0,0,0, 1,'h15, 1,0,0,0);
    a(0,0,   1,0,0,0, 0,'h15, 1,0,0,0);
    a(0,0,   1,1,0,0, 0,'h15, 0,1,0,0);
    // arbitration loss x3 -> dropped, next frame offered
    a(1,'h20,0,0,0,0, 0,'h15, 1,0,0,0);
    a(1,'h21,0,0,0,0, 1,'h20, 2,0,0,0);
    a(0,0,   1,0,0,0, 0,'h20, 2,0,0,0);
    a(0,0,   1,0,1,0, 0,'h20, 2,0,0,0);
    a(0,0,   0,0,0,0, 1,'h20, 2,0,0,0);
    a(0,0,   1,0,0,0, 0,'h20, 2,0,0,0);
    a(0,0,   1,0,1,0, 0,'h20, 2,0,0,0);
    a(0,0,   0,0,0,0, 1,'h20, 2,0,0,0);
    a(0,0,   1,0,0,0, 0,'h20, 2,0,0,0);
    a(0,0,   1,0,1,0, 0,'h20, 1,0,1,0);
    a(0,0,   0,0,0,0, 1,'h21, 1,0,0,0);
    a(0,0,   1,0,0,0, 0,'h21, 1,0,0,0);
    a(0,0,   1,1,0,0, 0,'h21, 0,1,0,0);
    // stray done/loss ignored; error frame re-offers
    a(1,'h30,0,0,1,0, 0,'h21, 1,0,0,0);
    a(0,0,   0,0,1,0, 1,'h30, 1,0,0,0);
    a(0,0,   1,0,0,0, 0,'h30, 1,0,0,0);
    a(0,0,   0,0,0,0, 0,'h30, 1,0,0,0);
    a(0,0,   0,1,0,0, 1,'h30, 1,0,0,0);
    a(0,0,   1,0,0,0, 0,'h30, 1,0,0,0);
    a(0,0,   1,1,0,0, 0,'h30, 0,1,0,0);
    // abort in READY flushes all
    a(1,'h40,0,0,0,0, 0,'h30, 1,0,0,0);
    a(1,'h41,0,0,0,0, 1,'h40, 2,0,0,0);
    a(1,'h42,0,0,0,0, 1,'h40, 3,0,0,0);
    a(0,0,   0,0,0,1, 0,'h40, 0,0,0,0);
    a(0,0,   0,0,0,0, 0,'h40, 0,0,0,0);
    // abort in ACTIVE keeps the head
    a(1,'h50,0,0,0,0, 0,'h40, 1,0,0,0);
    a(1,'h51,0,0,0,0, 1,'h50, 2,0,0,0);
    a(1,'h52,0,0,0,0, 1,'h50, 3,0,0,0);
    a(0,0,   1,0,0,0, 0,'h50, 3,0,0,0);
    a(0,0,   1,0,0,1, 0,'h50, 1,0,0,0);
    a(0,0,   1,1,0,0, 0,'h50, 0,1,0,0);
    a(0,0,   0,0,0,0, 0,'h50, 0,0,0,0);
    // abort and push together: push survives
    a(1,'h60,0,0,0,1, 0,'h50, 1,0,0,0);
    a(0,0,   0,0,0,0, 1,'h60, 1,0,0,0);
    a(0,0,   1,0,0,0, 0,'h60, 1,0,0,0);
    a(0,0,   1,1,0,0, 0,'h60, 0,1,0,0);

    @(posedge clk);
    #2;
    chk("rst_rdy", rdy, 0);
    chk("rst_occ", occ, 0);
    chk("rst_empty", empty, 0);
    chk("rst_full", full, 0);
    chk("rst_id", tid, 0);
    chk("rst_data", tdat, 0);
    chk("rst_pulses", {ovf, sent, drop}, 0);
    @(negedge clk);
    rst = 1'b0;
    setv(0, 0, 0, 0, 0, 0);
    step();
    chk("post_rst_empty", empty, 1);
    chk("post_rst_occ", occ, 0);

    set(1, 'h123, 4'd8, 0, 1, 64'h0123456789ABCDEF, 0, 0, 0, 0);
    step();
    chk("f1_rdy0", rdy, 0);
    chk("f1_occ1", occ, 1);
    chk("f1_empty0", empty, 0);
    setv(0, 0, 0, 0, 0, 0);
    step();
    chk("f1_rdy1", rdy, 1);
    chk("f1_id", tid, 'h123);
    chk("f1_size", tsz, 8);
    chk("f1_flags", {trtr, text}, 2'b01);
    chk("f1_data", tdat, 64'h0123456789ABCDEF);
    setv(0, 0, 1, 0, 0, 0);
    step();
    chk("f1_rdy_busy", rdy, 0);
    setv(0, 0, 1, 1, 0, 0);
    step();
    chk("f1_sent", sent, 1);
    chk("f1_occ0", occ, 0);
    setv(0, 0, 0, 0, 0, 0);
    step();
    chk("f1_sent_pulse", sent, 0);
    chk("f1_empty1", empty, 1);

    for (int i = 0; i < vt.size(); i++) begin
      setv(vt[i].push, vt[i].id, vt[i].busy, vt[i].done,
           vt[i].loss, vt[i].abort);
      step();
      chk($sformatf("v%0d_rdy", i), rdy, vt[i].rdy);
      chk($sformatf("v%0d_id", i), tid, vt[i].eid);
      chk($sformatf("v%0d_occ", i), occ, vt[i].occ);
      chk($sformatf("v%0d_sent", i), sent, vt[i].sent);
      chk($sformatf("v%0d_drop", i), drop, vt[i].drop);
      chk($sformatf("v%0d_ovf", i), ovf, vt[i].ovf);
      chk($sformatf("v%0d_empty", i), empty, vt[i].occ == 0);
      chk($sformatf("v%0d_full", i), full, vt[i].occ == 4);
      if (vt[i].rdy) begin
        chk($sformatf("v%0d_data", i), tdat, dat(vt[i].eid));
        chk($sformatf("v%0d_size", i), tsz, vt[i].eid[3:0]);
        chk($sformatf("v%0d_flags", i), {trtr, text},
            {vt[i].eid[0], vt[i].eid[1]});
      end
    end

    setv(1, 'h70, 0, 0, 0, 0);
    step();
    setv(0, 0, 0, 0, 0, 0);
    step();
    chk("r_rdy", rdy, 1);
    setv(0, 0, 1, 0, 0, 0);
    step();
    setv(1, 'h71, 1, 0, 0, 0);
    step();
    chk("r_occ2", occ, 2);
    @(negedge clk);
    push = 0;
    #2;
    rst = 1'b1;
    #1;
    chk("ar_rdy", rdy, 0);
    chk("ar_occ", occ, 0);
    chk("ar_id", tid, 0);
    chk("ar_data", tdat, 0);
    chk("ar_flags", {full, empty, ovf, sent, drop}, 0);
    @(negedge clk);
    rst = 1'b0;
    busy = 0;
    setv(0, 0, 0, 0, 0, 0);
    step();
    chk("ar_empty1", empty, 1);
    setv(1, 'h72, 0, 0, 0, 0);
    step();
    chk("ar_occ1", occ, 1);
    setv(0, 0, 0, 0, 0, 0);
    step();
    chk("ar_rdy1", rdy, 1);
    chk("ar_id72", tid, 'h72);
    chk("ar_data72", tdat, dat('h72));
    setv(0, 0, 1, 0, 0, 0);
    step();
    setv(0, 0, 1, 1, 0, 0);
    step();
    chk("ar_sent", sent, 1);
    chk("ar_occ0", occ, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
